ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter: the other direction of the keyboard link already received on PS2_CLK/PS2_DATA. It sends command bytes such as 0xED (set LEDs) and 0xFF (reset) to the keyboard. It drives both open-collector lines low via output-enable signals and otherwise only observes them. It sits beside the PS/2 receiver in topEntity, in the CLK_25MHZ domain, and shares the pads through tri-state buffers at the top level.

Parameters:
INHIBIT_CYCLES, 3000, clock-low inhibit time before the request (120 us at 25 MHz).
REQ_CYCLES, 250, data-low hold with clock still low before the clock is released (10 us).
TIMEOUT_CYCLES, 375000, maximum cycles from clock release to line-idle after ACK (15 ms).

Ports:
CLK_25MHZ  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
PS2_CLK_IN  in  1  raw PS/2 clock pad value (asynchronous).
PS2_DATA_IN  in  1  raw PS/2 data pad value (asynchronous).
PS2_CLK_OE  out  1  1 = pull PS/2 clock low; 0 = release.
PS2_DATA_OE  out  1  1 = pull PS/2 data low; 0 = release.
TX_VALID  in  1  command byte available.
TX_DATA  in  8  command byte.
TX_READY  out  1  high only in IDLE; a transfer is accepted when TX_VALID && TX_READY.
TX_DONE  out  1  one-cycle pulse: frame sent and ACK received.
TX_ERROR  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset values: PS2_CLK_OE=0, PS2_DATA_OE=0, TX_READY=1, TX_DONE=0, TX_ERROR=0, state IDLE, all counters 0. Reset asserted mid-frame releases both lines and takes effect immediately, with no pulse.
- Input synchronisers: both pad inputs pass through 2 flip-flops. A falling edge is detected when the registered previous synchronised clock is 1 and the current one is 0. Edge latency is 3 cycles from the pad; this is acceptable because the device clock runs at 10–16.7 kHz.
- Accept: in IDLE with TX_VALID=1, latch the shift register = {1 (stop), odd parity, TX_DATA[7:0]}, with LSB first after the start bit. Odd parity = ~^TX_DATA. Then go to INHIBIT. TX_VALID outside IDLE is ignored, not queued.
- INHIBIT: CLK_OE=1, DATA_OE=0, for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: CLK_OE=1, DATA_OE=1 (start bit), for REQ_CYCLES cycles. Then go to SEND, set CLK_OE=0, clear bit count to 0, and start the timeout counter.
- SEND: on each detected falling edge, present the next bit.
  - DATA_OE = ~bit, so a 1 is sent by releasing the line.
  - Edges 1–8 present data bits 0–7, edge 9 presents parity, edge 10 presents the stop bit (DATA_OE=0).
  - On edge 10, go to ACK.
- ACK: on the next falling edge (edge 11), sample synchronised data.
  - Data 0 is ACK: go to WAIT_IDLE.
  - Data 1 is NACK: pulse TX_ERROR and go to IDLE.
- WAIT_IDLE: wait until synchronised clock and data are both 1, pulse TX_DONE, go to IDLE.
- Timeout: the counter runs through SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1, release both lines, pulse TX_ERROR the following cycle, and go to IDLE. A timeout has priority over an edge detected in the same cycle.
- Exactly one of TX_DONE/TX_ERROR pulses per accepted byte. TX_READY returns high in the same cycle as the pulse.
- Both OEs are registered outputs; neither is ever driven combinationally from the inputs.
- While not in SEND or ACK, falling edges produced by the device (keyboard-to-host traffic) are ignored.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → clock held low ≥3000 cycles; data low at clock release; sampled bits on rising edges are 0,1,0,1,1,0,1,1,1, then parity=1, stop=1; TX_DONE pulses once; lines released.
- Send 0x02 → sampled data bits 0,1,0,0,0,0,0,0, parity=0, stop=1; TX_DONE.
- Device leaves data high at edge 11 (NACK) → TX_ERROR pulses once, no TX_DONE, both OEs 0, TX_READY=1.
- Device never clocks after release → TX_ERROR pulses exactly TIMEOUT_CYCLES(+1) cycles after entering SEND; OEs 0.
- Assert RESET after edge 5 of a frame → both OEs 0 immediately, no pulse. A following send of 0xFF completes with parity=1.
- TX_VALID held high during a frame with changing TX_DATA → transmitted byte equals the value latched at accept; a second transfer starts only after TX_READY returns.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-collector clock/data through output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int REQ_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERROR
);
  localparam int MAX_IR = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_C  = (TIMEOUT_CYCLES > MAX_IR) ? TIMEOUT_CYCLES : MAX_IR;
  localparam int W      = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [3:0]   bc_q, bc_d;
  logic [9:0]   sh_q, sh_d;
  logic [1:0]   ck_sync_q, dt_sync_q;
  logic         ck_prev_q;
  logic         clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic         done_q, done_d, err_q, err_d;
  logic         fall, tmo;
  assign fall        = ck_prev_q & ~ck_sync_q[1];
  assign tmo         = (state_q inside {SEND, ACK, WAIT_IDLE}) && (cnt_q == W'(TIMEOUT_CYCLES - 1));
  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;
  assign TX_READY    = (state_q == IDLE);
  assign TX_DONE     = done_q;
  assign TX_ERROR    = err_q;
  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bc_q      <= '0;
      sh_q      <= '0;
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
      ck_prev_q <= 1'b1;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bc_q      <= bc_d;
      sh_q      <= sh_d;
      ck_sync_q <= {ck_sync_q[0], PS2_CLK_IN};
      dt_sync_q <= {dt_sync_q[0], PS2_DATA_IN};
      ck_prev_q <= ck_sync_q[1];
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  // A timeout overrides whatever the line is doing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (tmo) state_d = IDLE;
    else case (state_q)
      IDLE:      state_d = TX_VALID ? INHIBIT : IDLE;
      INHIBIT:   state_d = (cnt_q == W'(INHIBIT_CYCLES - 1)) ? REQ : INHIBIT;
      REQ:       state_d = (cnt_q == W'(REQ_CYCLES - 1)) ? SEND : REQ;
      SEND:      state_d = (fall && bc_q == 4'd9) ? ACK : SEND;
      ACK:       state_d = fall ? (dt_sync_q[1] ? IDLE : WAIT_IDLE) : ACK;
      WAIT_IDLE: state_d = (ck_sync_q[1] && dt_sync_q[1]) ? IDLE : WAIT_IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // The counter keeps running from SEND through ACK and WAIT_IDLE so it bounds the whole exchange.
  always_comb begin
    cnt_d     = (state_d == IDLE || (state_d != state_q && !(state_d inside {ACK, WAIT_IDLE}))) ? '0 : cnt_q + 1'b1;
    bc_d      = (state_q == SEND) ? bc_q + {3'b000, fall} : 4'd0;
    sh_d      = (state_q == IDLE && TX_VALID) ? {1'b1, ~^TX_DATA, TX_DATA} :
                (state_q == SEND && fall) ? {1'b0, sh_q[9:1]} : sh_q;
    clk_oe_d  = state_d inside {INHIBIT, REQ};
    data_oe_d = (state_d == REQ) ||
                (state_d == SEND && (state_q != SEND || (fall ? !sh_q[0] : data_oe_q)));
    done_d    = !tmo && state_q == WAIT_IDLE && state_d == IDLE;
    err_d     = tmo || (state_q == ACK && state_d == IDLE);
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 host-transmit bench with a device model and a cycle-level reference model.
module tb_ps2_host_tx;
  localparam int I  = 40;
  localparam int R  = 12;
  localparam int T  = 1500;
  localparam int HP = 25;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clk_oe, data_oe, tx_ready, tx_done, tx_error;
  logic       pad_clk, pad_dat;
  int         n_cmp = 0, n_bad = 0, cyc = 0, acc = 0, n_acc = 0, mode = 0;
  bit         busy = 1'b0, pulse, fdone;
  logic [7:0] exp_q[$];
  assign pad_clk = dev_clk & ~clk_oe;
  assign pad_dat = dev_dat & ~data_oe;
  ps2_host_tx #(.INHIBIT_CYCLES(I), .REQ_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .CLK_25MHZ(clk), .RESET(rst), .PS2_CLK_IN(pad_clk), .PS2_DATA_IN(pad_dat),
    .PS2_CLK_OE(clk_oe), .PS2_DATA_OE(data_oe), .TX_VALID(tx_valid), .TX_DATA(tx_data),
    .TX_READY(tx_ready), .TX_DONE(tx_done), .TX_ERROR(tx_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
    n_cmp++;
    if (act !== ev) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, ev, cyc);
    end
  endtask
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
  // Reference model: accept bookkeeping, exact clock-inhibit window, pulse type and timeout cycle.
  initial forever begin
    @(negedge clk);
    if (rst) busy = 1'b0;
    else begin
      pulse = tx_done | tx_error;
      chk("ready", tx_ready, !busy || pulse);
      chk("clk_oe", clk_oe, busy && cyc >= acc && cyc < acc + I + R);
      if (busy && cyc >= acc && cyc <= acc + I + R) chk("data_oe_req", data_oe, cyc >= acc + I);
      chk("done_err_exclusive", tx_done & tx_error, 0);
      if (!busy) chk("stray_pulse", pulse, 0);
      else if (pulse) begin
        chk("pulse_is_done", tx_done, mode == 0);
        chk("lines_released", {clk_oe, data_oe}, 0);
        if (mode == 2) chk("timeout_cycle", cyc, acc + I + R + T);
        busy = 1'b0;
      end
      if (!busy && tx_valid) begin
        busy = 1'b1;
        acc = cyc + 1;
        exp_q.push_back(tx_data);
        n_acc++;
      end
    end
  end
  // Device: md 0 = ACK, 1 = NACK, 2 = never clocks; stop_at>0 stops after that many clock pulses.
  task automatic dev_frame(input int md, input int stop_at, output logic [10:0] got);
    int n;
    got = '0;
    n = 0;
    while (pad_clk && n < 100) begin @(negedge clk); n++; end
    chk("clk_pulled_low", pad_clk, 0);
    n = 0;
    while (!pad_clk && n < I + R + 100) begin @(negedge clk); n++; end
    chk("inhibit_long_enough", n >= I, 1);
    got[0] = pad_dat;
    if (md == 2) return;
    for (int i = 1; i <= 10; i++) begin
      repeat (HP) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      got[i] = pad_dat;
      dev_clk = 1'b1;
      if (i == stop_at) return;
    end
    repeat (HP) @(negedge clk);
    dev_dat = (md == 0) ? 1'b0 : 1'b1;
    repeat (2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HP) @(negedge clk);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    dev_dat = 1'b1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < T + 1000) begin @(negedge clk); n++; end
    chk("pulse_seen", busy, 0);
  endtask
  task automatic check_frame(input logic [10:0] got, input int md, input int upto);
    logic [7:0]  b;
    logic [10:0] e, mask;
    chk("byte_accepted", exp_q.size() > 0, 1);
    b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    e = frame_of(b);
    mask = 11'((12'd1 << (upto + 1)) - 12'd1);
    if (md == 2) chk("start_bit", got[0], e[0]);
    else if (upto > 0) chk("partial_frame", got & mask, e & mask);
    else chk("frame_bits", got, e);
  endtask
  task automatic run_frame(input logic [7:0] b, input int md, output logic [10:0] got);
    @(posedge clk); #1;
    mode = md; tx_data = b; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_frame(md, 0, got);
    wait_idle();
    check_frame(got, md, 0);
  endtask
  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [10:0] got;
    int k, n;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_error", tx_error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(8'hED, 0, got);
    chk("ed_literal", got, 11'b1_1_11101101_0);
    run_frame(8'h02, 0, got);
    chk("02_literal", got, 11'b1_0_00000010_0);
    run_frame(8'h81, 1, got);
    chk("nack_ready", tx_ready, 1);
    chk("nack_oes", {clk_oe, data_oe}, 0);
    run_frame(8'h55, 2, got);
    chk("timeout_oes", {clk_oe, data_oe}, 0);
    @(posedge clk); #1;
    mode = 0; tx_data = 8'h0F; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_frame(0, 5, got);
    chk("bit4_driven_low", data_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("reset_oes", {clk_oe, data_oe}, 0);
    chk("reset_pulses", {tx_done, tx_error}, 0);
    check_frame(got, 0, 5);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(8'hFF, 0, got);
    chk("ff_literal", got, 11'b1_1_11111111_0);
    k = n_acc;
    @(posedge clk); #1;
    mode = 0; tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h3C;
    fdone = 1'b0;
    fork
      begin dev_frame(0, 0, got); fdone = 1'b1; end
      begin while (!fdone) begin @(posedge clk); #1; tx_data = 8'($urandom); end end
    join
    n = 0;
    while (n_acc < k + 2 && n < 200) begin @(negedge clk); n++; end
    chk("reaccept_after_ready", n_acc, k + 2);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("held_first_byte", got[8:1], 8'hA5);
    check_frame(got, 0, 0);
    dev_frame(0, 0, got);
    wait_idle();
    check_frame(got, 0, 0);
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_frame(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, got);
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
